comparador: RTL and testbench



---
 rtl/comparador.sv | 69 ++++++
 tb/tb_comparador.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/comparador.sv
// Registered magnitude comparator stage: one-cycle latency, valid-qualified in/out,
// one-hot greater/less/equal flags, unsigned or two's-complement operands.
module comparador #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             AmaiorB,
    output logic             AmenorB,
    output logic             AigualB
);

    logic gt_c, lt_c, eq_c;
    logic valid_q, valid_d;
    logic gt_q, gt_d;
    logic lt_q, lt_d;
    logic eq_q, eq_d;

    // Full-width relational compare; no truncated subtraction, so no overflow case.
    generate
        if (SIGNED) begin : g_signed
            assign gt_c = $signed(A) > $signed(B);
            assign lt_c = $signed(A) < $signed(B);
        end else begin : g_unsigned
            assign gt_c = A > B;
            assign lt_c = A < B;
        end
    endgenerate

    assign eq_c = (A == B);

    // Flags only load when in_valid is high, so idle-cycle operand garbage never reaches them.
    always_comb begin
        valid_d = in_valid;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        if (in_valid) begin
            gt_d = gt_c;
            lt_d = lt_c;
            eq_d = eq_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign out_valid = valid_q;
    assign AmaiorB   = gt_q;
    assign AmenorB   = lt_q;
    assign AigualB   = eq_q;

endmodule

// File: tb/tb_comparador.sv
// Self-checking bench for comparador: unsigned/signed 4-bit and signed 32-bit instances
// checked against an integer-arithmetic reference model.
module tb_comparador;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  a, b;
    logic [31:0] a32, b32;

    logic ov_u, gt_u, lt_u, eq_u;
    logic ov_s, gt_s, lt_s, eq_s;
    logic ov_w, gt_w, lt_w, eq_w;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    comparador #(.WIDTH(4), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
        .out_valid(ov_u), .AmaiorB(gt_u), .AmenorB(lt_u), .AigualB(eq_u));

    comparador #(.WIDTH(4), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
        .out_valid(ov_s), .AmaiorB(gt_s), .AmenorB(lt_s), .AigualB(eq_s));

    comparador #(.WIDTH(32), .SIGNED(1'b1)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a32), .B(b32),
        .out_valid(ov_w), .AmaiorB(gt_w), .AmenorB(lt_w), .AigualB(eq_w));

    wire [3:0] obs_u = {ov_u, gt_u, lt_u, eq_u};
    wire [3:0] obs_s = {ov_s, gt_s, lt_s, eq_s};
    wire [3:0] obs_w = {ov_w, gt_w, lt_w, eq_w};

    // Numeric value of an operand as the spec defines it for the given width/mode.
    function automatic longint op_value(input logic [31:0] v, input int w, input bit s);
        longint x;
        x = longint'(v) & ((longint'(1) << w) - 1);
        if (s && v[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    // Returns {greater, less, equal}.
    function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y,
                                           input int w, input bit s);
        longint vx, vy;
        vx = op_value(x, w, s);
        vy = op_value(y, w, s);
        return {vx > vy, vx < vy, vx == vy};
    endfunction

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
        a32      = {{28{av[3]}}, av};
        b32      = {{28{bv[3]}}, bv};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 4'd9, 4'd6);
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({obs_u, obs_s, obs_w} !== 12'h000)
            $display("FAIL reset_hold: got u=%b s=%b w=%b, want all 0000", obs_u, obs_s, obs_w);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (obs_u !== 4'b1100)
            $display("FAIL reset_first_capture: got %b, want 1100", obs_u);
        else pass_cnt++;
        // Assert reset between edges; outputs must clear before the next edge.
        #3 rst = 1'b1;
        #1;
        total_cnt++;
        if ({obs_u, obs_s, obs_w} !== 12'h000)
            $display("FAIL reset_async: got u=%b s=%b w=%b, want all 0000", obs_u, obs_s, obs_w);
        else pass_cnt++;
    endtask

    task automatic test_reset_race;
        rst = 1'b1;
        drive(1'b1, 4'd3, 4'd3);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total_cnt++;
        if (obs_u !== 4'b0000)
            $display("FAIL reset_race_drop: got %b, want 0000", obs_u);
        else pass_cnt++;
        drive(1'b0, 4'd0, 4'd0);
        @(posedge clk); #1;
        total_cnt++;
        if (ov_u !== 1'b0 || ov_s !== 1'b0)
            $display("FAIL reset_race_idle: got out_valid u=%b s=%b, want 0", ov_u, ov_s);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        logic [3:0] ta [5] = '{4'b0101, 4'b1001, 4'b0011, 4'b1111, 4'b0000};
        logic [3:0] tb [5] = '{4'b0101, 4'b0110, 4'b1110, 4'b1111, 4'b0001};
        logic [3:0] te [5] = '{4'b1001, 4'b1100, 4'b1010, 4'b1001, 4'b1010};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ta[i], tb[i]);
            @(posedge clk); #1;
            total_cnt++;
            if (obs_u !== te[i])
                $display("FAIL basic_uns[%0d] A=%b B=%b: got %b, want %b", i, ta[i], tb[i], obs_u, te[i]);
            else pass_cnt++;
            total_cnt++;
            if (obs_s !== {1'b1, ref_cmp({28'd0, ta[i]}, {28'd0, tb[i]}, 4, 1'b1)})
                $display("FAIL basic_sgn[%0d] A=%b B=%b: got %b", i, ta[i], tb[i], obs_s);
            else pass_cnt++;
        end
    endtask

    task automatic test_gating;
        drive(1'b1, 4'd9, 4'd6);
        @(posedge clk); #1;
        total_cnt++;
        if (obs_u !== 4'b1100)
            $display("FAIL gating_capture: got %b, want 1100", obs_u);
        else pass_cnt++;
        drive(1'b0, 4'd0, 4'd15);
        @(posedge clk); #1;
        total_cnt++;
        if (obs_u !== 4'b0100)
            $display("FAIL gating_hold: got %b, want 0100", obs_u);
        else pass_cnt++;
    endtask

    task automatic test_signed;
        logic [3:0] ta [3] = '{4'b1111, 4'b0111, 4'b1000};
        logic [3:0] tb [3] = '{4'b0001, 4'b1000, 4'b1000};
        logic [3:0] te [3] = '{4'b1010, 4'b1100, 4'b1001};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ta[i], tb[i]);
            @(posedge clk); #1;
            total_cnt++;
            if (obs_s !== te[i])
                $display("FAIL signed[%0d] A=%b B=%b: got %b, want %b", i, ta[i], tb[i], obs_s, te[i]);
            else pass_cnt++;
        end
        // F vs 0: greater unsigned, less signed.
        drive(1'b1, 4'hF, 4'h0);
        @(posedge clk); #1;
        total_cnt++;
        if (obs_u !== 4'b1100 || obs_s !== 4'b1010)
            $display("FAIL boundary_F_0: got u=%b s=%b, want u=1100 s=1010", obs_u, obs_s);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [2:0] eu, es;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, i[7:4], i[3:0]);
            eu = ref_cmp({28'd0, i[7:4]}, {28'd0, i[3:0]}, 4, 1'b0);
            es = ref_cmp({28'd0, i[7:4]}, {28'd0, i[3:0]}, 4, 1'b1);
            @(posedge clk); #1;
            total_cnt++;
            if (obs_u !== {1'b1, eu} || !$onehot(obs_u[2:0]))
                $display("FAIL exh_uns A=%h B=%h: got %b, want 1%b", i[7:4], i[3:0], obs_u, eu);
            else pass_cnt++;
            total_cnt++;
            if (obs_s !== {1'b1, es} || !$onehot(obs_s[2:0]))
                $display("FAIL exh_sgn A=%h B=%h: got %b, want 1%b", i[7:4], i[3:0], obs_s, es);
            else pass_cnt++;
        end
    endtask

    task automatic test_random;
        logic [2:0] hold_u, hold_s, hold_w;
        logic       v;
        hold_u = 3'b000; hold_s = 3'b000; hold_w = 3'b000;
        for (int i = 0; i < 300; i++) begin
            v = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            drive(v, 4'($urandom), 4'($urandom));
            a32 = $urandom;
            b32 = ($urandom_range(0, 7) == 0) ? a32 : $urandom;
            if (v) begin
                hold_u = ref_cmp({28'd0, a}, {28'd0, b}, 4, 1'b0);
                hold_s = ref_cmp({28'd0, a}, {28'd0, b}, 4, 1'b1);
                hold_w = ref_cmp(a32, b32, 32, 1'b1);
            end
            @(posedge clk); #1;
            total_cnt++;
            if (obs_u !== {v, hold_u} || obs_s !== {v, hold_s})
                $display("FAIL rand4[%0d]: got u=%b s=%b, want u=%b s=%b", i, obs_u, obs_s, {v, hold_u}, {v, hold_s});
            else pass_cnt++;
            total_cnt++;
            if (obs_w !== {v, hold_w})
                $display("FAIL rand32[%0d] A=%h B=%h: got %b, want %b", i, a32, b32, obs_w, {v, hold_w});
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0);
        test_reset();
        test_reset_race();
        test_basic();
        test_gating();
        test_signed();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
